// File: rtl/dump_pkg.sv
// Shared types and constants for the data-memory dump transmitter.
// Frame layout: header byte, one byte per address, checksum byte.
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4
  } dump_state_t;

  localparam int          DEFAULT_ADDR_W = 4;
  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int          FRAME_LEN      = (2 ** DEFAULT_ADDR_W) + 2;

endpackage

// File: rtl/dmem_dump.sv
// Streams the data-memory image out as header, data bytes and an additive checksum
// over valid/ready, started by a rising edge of trigger (normally halt).
//
// state  | meaning
// IDLE   | waiting for a trigger rising edge; read_addr parked at 0
// HEADER | header byte presented
// DATA   | memory bytes presented, address counter walking the memory
// CSUM   | checksum byte presented
// DONE   | one-cycle completion pulse
module dmem_dump
  import dump_pkg::*;
#(
  parameter int                ADDR_W = DEFAULT_ADDR_W,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] HEADER = DATA_W'(HEADER_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  dump_state_t       state, state_n;
  logic              trig_q;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] csum, csum_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              valid_q, valid_n;
  logic              wrapped, wrapped_n;
  logic              start;
  logic              xfer;

  assign start = trigger && !trig_q;
  assign xfer  = valid_q && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      trig_q  <= 1'b0;
      addr    <= '0;
      csum    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      state   <= state_n;
      trig_q  <= trigger;
      addr    <= addr_n;
      csum    <= csum_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      wrapped <= wrapped_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    csum_n    = csum;
    data_n    = data_q;
    valid_n   = valid_q;
    wrapped_n = wrapped;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_HEADER;
          data_n    = HEADER;
          valid_n   = 1'b1;
          addr_n    = '0;
          csum_n    = '0;
          wrapped_n = 1'b0;
        end
      end
      ST_HEADER: begin
        if (xfer) begin
          data_n    = read_data;
          csum_n    = csum + read_data;
          addr_n    = addr + 1'b1;
          wrapped_n = (addr == '1);
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          // Counter wraps back to 0 after the last address, leaving read_addr parked for IDLE.
          if (!wrapped) begin
            data_n    = read_data;
            csum_n    = csum + read_data;
            addr_n    = addr + 1'b1;
            wrapped_n = (addr == '1);
          end else begin
            data_n  = csum;
            state_n = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          valid_n = 1'b0;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  assign read_addr = addr;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule
